delta_liafn_scheduler: RTL and testbench

- Time-multiplexes one leaky integrate-and-fire update datapath across N_NEURONS virtual delta neurons.
- Each neuron keeps its membrane state in an internal register file.
- Per timestep the block fetches one input current per neuron, applies leak plus integrate, and compares the new state with the previous one.
- When the positive change reaches the delta threshold, it emits a spike event (neuron id plus delta) over a valid/ready handshake.
- It sits between the chip-level input sampler and the spike/debug output path.

---
 rtl/delta_liafn_scheduler.sv | 126 ++++++++++++
 tb/tb_delta_liafn_scheduler.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/delta_liafn_scheduler.sv
// Time-multiplexed leaky integrate-and-fire datapath shared by N_NEURONS delta neurons.
// Emits (id, delta) events when a neuron's state rises by at least DELTA_THRESHOLD in a timestep.
module delta_liafn_scheduler #(
  parameter int N_NEURONS       = 4,
  parameter int WIDTH           = 8,
  parameter int DELTA_THRESHOLD = 10,
  parameter int LEAK_SHIFT      = 1,
  localparam int IDX_W          = $clog2(N_NEURONS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             cur_req,
  output logic [IDX_W-1:0] cur_addr,
  input  logic             cur_valid,
  input  logic [WIDTH-1:0] cur_data,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [IDX_W-1:0] evt_id,
  output logic [WIDTH-1:0] evt_delta,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] state_mon
);

  localparam logic [WIDTH-1:0] THRESHOLD = WIDTH'(DELTA_THRESHOLD);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_NEURONS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_UPDATE,
    S_EMIT,
    S_DONE
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] cur_lat;
  logic [WIDTH-1:0] mem [N_NEURONS];

  logic [WIDTH-1:0] old_state;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] new_state;
  logic [WIDTH-1:0] diff;
  logic             fire;
  logic             last;

  // Leak can never exceed the old state, so the WIDTH+1 bit sum only overflows upward.
  always_comb begin
    old_state = mem[idx];
    sum       = {1'b0, old_state} - ({1'b0, old_state} >> LEAK_SHIFT) + {1'b0, cur_lat};
    new_state = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
    diff      = new_state - old_state;
    fire      = (new_state > old_state) && (diff >= THRESHOLD);
    last      = (idx == LAST_IDX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH:  if (cur_valid) state_d = S_UPDATE;
      S_UPDATE: begin
        if (fire)      state_d = S_EMIT;
        else if (last) state_d = S_DONE;
        else           state_d = S_FETCH;
      end
      S_EMIT: begin
        if (evt_ready) state_d = last ? S_DONE : S_FETCH;
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // idx only advances once the current neuron is fully retired (update or event transfer).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      cur_lat   <= '0;
      evt_id    <= '0;
      evt_delta <= '0;
      for (int i = 0; i < N_NEURONS; i++) begin
        mem[i] <= '0;
      end
    end else begin
      case (state_q)
        S_FETCH: begin
          if (cur_valid) cur_lat <= cur_data;
        end
        S_UPDATE: begin
          mem[idx] <= new_state;
          if (fire) begin
            evt_id    <= idx;
            evt_delta <= diff;
          end else if (!last) begin
            idx <= idx + 1'b1;
          end
        end
        S_EMIT: begin
          if (evt_ready && !last) idx <= idx + 1'b1;
        end
        S_DONE:   idx <= '0;
        default:  ;
      endcase
    end
  end

  assign cur_req   = (state_q == S_FETCH);
  assign cur_addr  = idx;
  assign evt_valid = (state_q == S_EMIT);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign state_mon = mem[idx];

endmodule

// File: tb/tb_delta_liafn_scheduler.sv
// Directed bench for delta_liafn_scheduler: hand-computed currents, states and events per timestep.
module tb_delta_liafn_scheduler;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       cur_req;
  logic [1:0] cur_addr;
  logic       cur_valid;
  logic [7:0] cur_data;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_id;
  logic [7:0] evt_delta;
  logic       busy;
  logic       done;
  logic [7:0] state_mon;

  int compares = 0;
  int fails    = 0;

  delta_liafn_scheduler #(
    .N_NEURONS(4),
    .WIDTH(8),
    .DELTA_THRESHOLD(10),
    .LEAK_SHIFT(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .cur_req(cur_req),
    .cur_addr(cur_addr),
    .cur_valid(cur_valid),
    .cur_data(cur_data),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_id(evt_id),
    .evt_delta(evt_delta),
    .busy(busy),
    .done(done),
    .state_mon(state_mon)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compares++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_cur_req"},   cur_req,   0);
    check_output({tag, "_cur_addr"},  cur_addr,  0);
    check_output({tag, "_evt_valid"}, evt_valid, 0);
    check_output({tag, "_evt_id"},    evt_id,    0);
    check_output({tag, "_evt_delta"}, evt_delta, 0);
    check_output({tag, "_busy"},      busy,      0);
    check_output({tag, "_done"},      done,      0);
    check_output({tag, "_state_mon"}, state_mon, 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_output("busy_after_start", busy, 1);
  endtask

  // One neuron: optional cur_valid delay, optional evt_ready backpressure (with a stray start pulse).
  task automatic apply_stimulus(input int id, input logic [7:0] exp_old, input logic [7:0] cur,
                                input logic [7:0] exp_new, input bit exp_evt,
                                input int valid_delay, input int ready_delay);
    int n;
    logic [7:0] exp_delta;
    exp_delta = exp_new - exp_old;
    n = 0;
    while (!cur_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_output("cur_req_seen", cur_req, 1);
    check_output("cur_addr", cur_addr, id);
    check_output("state_old", state_mon, exp_old);
    for (int i = 0; i < valid_delay; i++) begin
      @(negedge clk);
      check_output("cur_req_hold", cur_req, 1);
      check_output("state_unchanged", state_mon, exp_old);
    end
    cur_valid = 1'b1;
    cur_data  = cur;
    @(negedge clk);
    cur_valid = 1'b0;
    cur_data  = 8'($urandom);
    check_output("cur_req_drop", cur_req, 0);
    @(negedge clk);
    check_output("evt_valid", evt_valid, exp_evt);
    if (exp_evt) begin
      check_output("evt_id", evt_id, id);
      check_output("evt_delta", evt_delta, exp_delta);
      check_output("state_new", state_mon, exp_new);
      if (ready_delay > 0) begin
        evt_ready = 1'b0;
        start     = 1'b1;
        for (int i = 0; i < ready_delay; i++) begin
          @(negedge clk);
          start = 1'b0;
          check_output("bp_evt_valid", evt_valid, 1);
          check_output("bp_evt_id", evt_id, id);
          check_output("bp_evt_delta", evt_delta, exp_delta);
          check_output("bp_cur_req", cur_req, 0);
        end
        evt_ready = 1'b1;
      end
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_output("done_pulse", done, 1);
    check_output("busy_in_done", busy, 1);
    @(negedge clk);
    check_output("done_drop", done, 0);
    check_output("busy_drop", busy, 0);
    check_output("evt_valid_idle", evt_valid, 0);
    @(negedge clk);
    check_output("stay_idle", busy, 0);
  endtask

  task automatic scenario_first_step();
    pulse_start();
    apply_stimulus(0, 8'd0, 8'd20, 8'd20, 1'b1, 0, 0);
    apply_stimulus(1, 8'd0, 8'd5,  8'd5,  1'b0, 0, 0);
    apply_stimulus(2, 8'd0, 8'd10, 8'd10, 1'b1, 0, 0);
    apply_stimulus(3, 8'd0, 8'd0,  8'd0,  1'b0, 0, 0);
    wait_done();
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    cur_valid = 1'b0;
    cur_data  = 8'd0;
    evt_ready = 1'b0;

    // Reset held with random inputs: every output must stay zero.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start     = 1'($urandom);
      cur_valid = 1'($urandom);
      cur_data  = 8'($urandom);
      evt_ready = 1'($urandom);
      #1;
      check_all_zero("reset");
    end
    @(negedge clk);
    start     = 1'b0;
    cur_valid = 1'b0;
    cur_data  = 8'd0;
    evt_ready = 1'b1;
    rst_n     = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset");

    $display("[TB] zero-current timestep");
    pulse_start();
    for (int i = 0; i < 4; i++) apply_stimulus(i, 8'd0, 8'd0, 8'd0, 1'b0, 0, 0);
    wait_done();

    $display("[TB] currents 20,5,10,0");
    scenario_first_step();

    $display("[TB] all currents 20 with backpressure and delayed valid");
    pulse_start();
    apply_stimulus(0, 8'd20, 8'd20, 8'd30, 1'b1, 0, 0);
    apply_stimulus(1, 8'd5,  8'd20, 8'd23, 1'b1, 0, 5);
    apply_stimulus(2, 8'd10, 8'd20, 8'd25, 1'b1, 3, 0);
    apply_stimulus(3, 8'd0,  8'd20, 8'd20, 1'b1, 0, 0);
    wait_done();

    $display("[TB] drive neuron 0 to 200");
    pulse_start();
    apply_stimulus(0, 8'd30, 8'd185, 8'd200, 1'b1, 0, 0);
    apply_stimulus(1, 8'd23, 8'd0,   8'd12,  1'b0, 0, 0);
    apply_stimulus(2, 8'd25, 8'd0,   8'd13,  1'b0, 0, 0);
    apply_stimulus(3, 8'd20, 8'd0,   8'd10,  1'b0, 0, 0);
    wait_done();

    $display("[TB] saturation");
    pulse_start();
    apply_stimulus(0, 8'd200, 8'd250, 8'd255, 1'b1, 0, 0);
    apply_stimulus(1, 8'd12,  8'd24,  8'd30,  1'b1, 0, 0);
    apply_stimulus(2, 8'd13,  8'd0,   8'd7,   1'b0, 0, 0);
    apply_stimulus(3, 8'd10,  8'd0,   8'd5,   1'b0, 0, 0);
    wait_done();

    $display("[TB] pure leak");
    pulse_start();
    apply_stimulus(0, 8'd255, 8'd0, 8'd128, 1'b0, 0, 0);
    apply_stimulus(1, 8'd30,  8'd0, 8'd15,  1'b0, 0, 0);
    apply_stimulus(2, 8'd7,   8'd0, 8'd4,   1'b0, 0, 0);
    apply_stimulus(3, 8'd5,   8'd0, 8'd3,   1'b0, 0, 0);
    wait_done();

    $display("[TB] reset during EMIT");
    evt_ready = 1'b0;
    pulse_start();
    apply_stimulus(0, 8'd128, 8'd100, 8'd164, 1'b1, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("rst_evt_valid", evt_valid, 0);
    check_output("rst_evt_delta", evt_delta, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_state_mon", state_mon, 0);
    @(negedge clk);
    @(negedge clk);
    evt_ready = 1'b1;
    rst_n     = 1'b1;
    @(negedge clk);
    check_all_zero("after_abort");
    scenario_first_step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
